// File: rtl/cordic_seq_if.sv
`default_nettype none
// ============================================================================
// cordic_seq_if : UDM debug-bus signalling (MemSplit32 slave side)
// Revision      : 1.0
// ============================================================================
interface cordic_seq_if;
    logic        bus_req_i;
    logic        bus_we_i;
    logic [31:0] bus_addr_bi;
    logic [3:0]  bus_be_bi;
    logic [31:0] bus_wdata_bi;
    logic        bus_ack_o;
    logic        bus_resp_o;
    logic [31:0] bus_rdata_bo;

    modport slave (
        input  bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
        output bus_ack_o, bus_resp_o, bus_rdata_bo
    );

    modport master (
        output bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
        input  bus_ack_o, bus_resp_o, bus_rdata_bo
    );
endinterface
`default_nettype wire

// File: rtl/cordic_seq.sv
`default_nettype none
// ============================================================================
// cordic_seq : bus-fed angle/result FIFOs sequencing cos_CORDIC jobs
//              optional per-job watchdog: define CORDIC_SEQ_TIMEOUT_EN
// Revision   : 1.0
// ============================================================================
module cordic_seq #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0010,
    parameter int          DEPTH_POW      = 2,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  wire         clk_i,
    input  wire         rst_i,
    cordic_seq_if.slave bus,
    output logic        cordic_start_o,
    output logic [31:0] cordic_angle_bo,
    input  wire         cordic_ready_i,
    input  wire  [31:0] cordic_cos_bi
);
    localparam int DEPTH = 1 << DEPTH_POW;
    localparam int CW    = DEPTH_POW + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_STORE     = 3'd4,
        S_DRAIN     = 3'd5
    } state_t;

    state_t state, state_nxt;
    logic   tmo_hit, wd_expire, tmo_abort;

    logic [31:0]          a_mem [DEPTH];
    logic [31:0]          r_mem [DEPTH];
    logic [DEPTH_POW-1:0] a_wr, a_rd, r_wr, r_rd;
    logic [CW-1:0]        a_cnt, r_cnt;
    logic                 ovf, udf, tmo;
    logic [31:0]          jobs;
    logic                 resp;
    logic [31:0]          rdata;

    wire        hit     = bus.bus_addr_bi[31:4] == BASE_ADDR[31:4];
    wire [1:0]  sel     = bus.bus_addr_bi[3:2];
    wire        ack     = bus.bus_req_i && hit;
    wire        wr_acc  = ack && bus.bus_we_i;
    wire        rd_acc  = ack && !bus.bus_we_i;
    wire        unused_bits = ^{bus.bus_be_bi, bus.bus_addr_bi[1:0]};

    wire flush      = wr_acc && sel == 2'd0 && bus.bus_wdata_bi[0];
    wire clr_sticky = wr_acc && sel == 2'd0 && bus.bus_wdata_bi[1];
    wire a_push_req = wr_acc && sel == 2'd1;
    wire r_pop_req  = rd_acc && sel == 2'd2;
    wire jobs_clr   = wr_acc && sel == 2'd3;

    wire a_full  = a_cnt == CW'(DEPTH);
    wire a_empty = a_cnt == '0;
    wire r_full  = r_cnt == CW'(DEPTH);
    wire r_empty = r_cnt == '0;

    // Pops are resolved before pushes, so a full angle FIFO accepts a push
    // in the cycle the FSM takes its head; flush overrides both.
    wire a_pop   = state == S_IDLE && !a_empty && !r_full && !flush;
    wire a_push  = a_push_req && (!a_full || a_pop) && !flush;
    wire ovf_set = a_push_req && a_full && !a_pop && !flush;
    wire r_pop   = r_pop_req && !r_empty && !flush;
    wire udf_set = r_pop_req && r_empty;
    wire r_push  = state == S_STORE && (!r_full || r_pop) && !flush;
    wire [31:0] r_din = tmo_abort ? 32'h8000_0000 : cordic_cos_bi;

`ifdef CORDIC_SEQ_TIMEOUT_EN
    logic [31:0] wd;
    wire waiting = state == S_WAIT_BUSY || state == S_WAIT_DONE || state == S_DRAIN;
    assign wd_expire = waiting && wd == 32'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                   wd <= '0;
        else if (state_nxt != state) wd <= '0;
        else if (waiting)            wd <= wd + 32'd1;
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        tmo_hit   = 1'b0;
        case (state)
            S_IDLE:      if (a_pop) state_nxt = S_LAUNCH;
            S_LAUNCH:    state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (flush)                state_nxt = S_DRAIN;
                else if (wd_expire)       begin state_nxt = S_STORE; tmo_hit = 1'b1; end
                else if (!cordic_ready_i) state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (flush)               state_nxt = S_DRAIN;
                else if (cordic_ready_i) state_nxt = S_STORE;
                else if (wd_expire)      begin state_nxt = S_STORE; tmo_hit = 1'b1; end
            end
            S_STORE:     state_nxt = S_IDLE;
            S_DRAIN: begin
                if (cordic_ready_i) state_nxt = S_IDLE;
                else if (wd_expire) begin state_nxt = S_IDLE; tmo_hit = 1'b1; end
            end
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            tmo_abort       <= 1'b0;
            cordic_angle_bo <= '0;
        end else begin
            state     <= state_nxt;
            tmo_abort <= tmo_hit && state_nxt == S_STORE;
            if (a_pop) cordic_angle_bo <= a_mem[a_rd];
        end
    end

    assign cordic_start_o = state == S_LAUNCH;

    always_ff @(posedge clk_i) begin
        if (a_push) a_mem[a_wr] <= bus.bus_wdata_bi;
        if (r_push) r_mem[r_wr] <= r_din;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_wr <= '0; a_rd <= '0; a_cnt <= '0;
            r_wr <= '0; r_rd <= '0; r_cnt <= '0;
        end else if (flush) begin
            a_wr <= '0; a_rd <= '0; a_cnt <= '0;
            r_wr <= '0; r_rd <= '0; r_cnt <= '0;
        end else begin
            if (a_push) a_wr <= a_wr + 1'b1;
            if (a_pop)  a_rd <= a_rd + 1'b1;
            if (r_push) r_wr <= r_wr + 1'b1;
            if (r_pop)  r_rd <= r_rd + 1'b1;
            case ({a_push, a_pop})
                2'b10:   a_cnt <= a_cnt + 1'b1;
                2'b01:   a_cnt <= a_cnt - 1'b1;
                default: a_cnt <= a_cnt;
            endcase
            case ({r_push, r_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf <= 1'b0; udf <= 1'b0; tmo <= 1'b0;
            jobs <= '0;
        end else begin
            if (clr_sticky) begin ovf <= 1'b0; udf <= 1'b0; tmo <= 1'b0; end
            if (ovf_set) ovf <= 1'b1;
            if (udf_set) udf <= 1'b1;
            if (tmo_hit) tmo <= 1'b1;
            if (jobs_clr)             jobs <= '0;
            else if (state == S_STORE) jobs <= jobs + 32'd1;
        end
    end

    logic [31:0] rd_val;
    always_comb begin
        rd_val = '0;
        case (sel)
            2'd0:    rd_val = {state != S_IDLE, ovf, udf, tmo, 12'd0, 8'(r_cnt), 8'(a_cnt)};
            2'd2:    rd_val = r_empty ? 32'd0 : r_mem[r_rd];
            2'd3:    rd_val = jobs;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp  <= 1'b0;
            rdata <= '0;
        end else begin
            resp  <= rd_acc;
            rdata <= rd_acc ? rd_val : 32'd0;
        end
    end

    assign bus.bus_ack_o    = ack;
    assign bus.bus_resp_o   = resp;
    assign bus.bus_rdata_bo = rdata;
endmodule
`default_nettype wire
